pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 22 ++
 rtl/pipeline_ctrl_sat_counter.sv | 30 +++
 rtl/pipeline_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the CPU pipeline control slice:
//   - ctrl_state_e : multicycle sequencing states of the hazard controller
//   - STAGE_*      : stage index constants used to address per-stage hold/clear vectors
//   - MC_CNT_W     : width of the multicycle hold down-counter
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    MC_DONE = 2'd2
  } ctrl_state_e;

  localparam int STAGE_FE  = 0;
  localparam int STAGE_DE  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  localparam int MC_CNT_W = 8;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (count -> 0)
//   inc   - count up by one on this edge (sticks at all-ones)
//   clr   - synchronous clear, takes priority over inc
//   count - current count value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins over increment; once all-ones the count stays put.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Hazard/stall controller for a 5-stage pipeline (FE, DE, EX, MEM, WB).
// Parameters:
//   MC_LAT - total EX hold cycles for a multicycle op (2..255)
//   CNT_W  - width of the stall-cycle counter
// Ports:
//   clk, reset (async, active-low)
//   mem_busy, ex_multicycle, branch_taken, load_use - hazard inputs
//   cnt_clr                                         - clears stall_cycles
//   hold_fe/de/ex/mem                               - stage register holds
//   clear_de/ex/mem/wb                              - stage register bubbles
//   stall_cycles                                    - cycles with hold_fe high
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_busy,
  input  logic             ex_multicycle,
  input  logic             branch_taken,
  input  logic             load_use,
  input  logic             cnt_clr,
  output logic             hold_fe,
  output logic             hold_de,
  output logic             hold_ex,
  output logic             hold_mem,
  output logic             clear_de,
  output logic             clear_ex,
  output logic             clear_mem,
  output logic             clear_wb,
  output logic [CNT_W-1:0] stall_cycles
);

  // The entry cycle counts as one hold and the cycle that sees mc_cnt == 0
  // counts as another, so the counter starts two below the total latency.
  localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LAT - 2);

  ctrl_state_e                state, state_nxt;
  logic [MC_CNT_W-1:0]        mc_cnt, mc_cnt_nxt;
  logic [STAGE_MEM:STAGE_FE]  hold_vec;
  logic [STAGE_WB:STAGE_DE]   clear_vec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
    end
  end

  // Outputs depend on the live reset level so that bubbles are injected
  // into every stage the moment reset asserts, not at the next edge.
  // mem_busy freezes everything because the whole pipe must wait on memory.
  always_comb begin
    state_nxt  = state;
    mc_cnt_nxt = mc_cnt;
    hold_vec   = '0;
    clear_vec  = '0;

    if (!reset) begin
      clear_vec = '1;
    end else if (mem_busy) begin
      hold_vec            = '1;
      clear_vec[STAGE_WB] = 1'b1;
    end else begin
      case (state)
        MC_WAIT: begin
          hold_vec[STAGE_FE]   = 1'b1;
          hold_vec[STAGE_DE]   = 1'b1;
          hold_vec[STAGE_EX]   = 1'b1;
          clear_vec[STAGE_MEM] = 1'b1;
          if (mc_cnt == '0) begin
            state_nxt = MC_DONE;
          end else begin
            mc_cnt_nxt = mc_cnt - 1'b1;
          end
        end
        default: begin
          // MC_DONE ignores ex_multicycle: the op just finished is still
          // asserting it while it leaves EX.
          if ((state == RUN) && ex_multicycle) begin
            hold_vec[STAGE_FE]   = 1'b1;
            hold_vec[STAGE_DE]   = 1'b1;
            hold_vec[STAGE_EX]   = 1'b1;
            clear_vec[STAGE_MEM] = 1'b1;
            mc_cnt_nxt           = MC_LOAD;
            state_nxt            = MC_WAIT;
          end else begin
            state_nxt = RUN;
            if (branch_taken) begin
              clear_vec[STAGE_DE] = 1'b1;
              clear_vec[STAGE_EX] = 1'b1;
            end else if (load_use) begin
              hold_vec[STAGE_FE]  = 1'b1;
              hold_vec[STAGE_DE]  = 1'b1;
              clear_vec[STAGE_EX] = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign hold_fe   = hold_vec[STAGE_FE];
  assign hold_de   = hold_vec[STAGE_DE];
  assign hold_ex   = hold_vec[STAGE_EX];
  assign hold_mem  = hold_vec[STAGE_MEM];
  assign clear_de  = clear_vec[STAGE_DE];
  assign clear_ex  = clear_vec[STAGE_EX];
  assign clear_mem = clear_vec[STAGE_MEM];
  assign clear_wb  = clear_vec[STAGE_WB];

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (hold_fe),
    .clr  (cnt_clr),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Drives a default-width controller and a CNT_W=4 controller from the same
// inputs. A behavioural model tracks "hold cycles left in the current
// multicycle op", a one-cycle "just finished" flag and the two stall counts,
// and is compared against both instances on every falling edge. Directed
// literal checks pin the model to hand-computed scenarios.
module tb_pipeline_ctrl;

  localparam int MC_LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_busy, ex_multicycle, branch_taken, load_use, cnt_clr;

  logic        hold_fe, hold_de, hold_ex, hold_mem;
  logic        clear_de, clear_ex, clear_mem, clear_wb;
  logic [31:0] stall_cycles;

  logic        s_hold_fe, s_hold_de, s_hold_ex, s_hold_mem;
  logic        s_clear_de, s_clear_ex, s_clear_mem, s_clear_wb;
  logic [3:0]  s_stall_cycles;

  logic [7:0]  dut_vec, s_vec;

  int          assert_count = 0;
  int          fail_count   = 0;

  int          op_left;
  bit          cooldown;
  longint      stall_big;
  int          stall_small;

  pipeline_ctrl #(.MC_LAT(MC_LAT), .CNT_W(32)) dut (
    .clk(clk), .reset(rst_n),
    .mem_busy(mem_busy), .ex_multicycle(ex_multicycle),
    .branch_taken(branch_taken), .load_use(load_use), .cnt_clr(cnt_clr),
    .hold_fe(hold_fe), .hold_de(hold_de), .hold_ex(hold_ex), .hold_mem(hold_mem),
    .clear_de(clear_de), .clear_ex(clear_ex), .clear_mem(clear_mem), .clear_wb(clear_wb),
    .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.MC_LAT(MC_LAT), .CNT_W(4)) dut_small (
    .clk(clk), .reset(rst_n),
    .mem_busy(mem_busy), .ex_multicycle(ex_multicycle),
    .branch_taken(branch_taken), .load_use(load_use), .cnt_clr(cnt_clr),
    .hold_fe(s_hold_fe), .hold_de(s_hold_de), .hold_ex(s_hold_ex), .hold_mem(s_hold_mem),
    .clear_de(s_clear_de), .clear_ex(s_clear_ex), .clear_mem(s_clear_mem), .clear_wb(s_clear_wb),
    .stall_cycles(s_stall_cycles)
  );

  // Bit order: hold_fe, hold_de, hold_ex, hold_mem, clear_de, clear_ex, clear_mem, clear_wb
  assign dut_vec = {hold_fe, hold_de, hold_ex, hold_mem, clear_de, clear_ex, clear_mem, clear_wb};
  assign s_vec   = {s_hold_fe, s_hold_de, s_hold_ex, s_hold_mem,
                    s_clear_de, s_clear_ex, s_clear_mem, s_clear_wb};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic mb, input logic mc, input logic br,
                               input logic lu, input logic clr);
    @(posedge clk);
    #1;
    mem_busy      = mb;
    ex_multicycle = mc;
    branch_taken  = br;
    load_use      = lu;
    cnt_clr       = clr;
  endtask

  function automatic void model_reset();
    op_left     = 0;
    cooldown    = 1'b0;
    stall_big   = 0;
    stall_small = 0;
  endfunction

  // Expected control vector from the priority rules.
  function automatic logic [7:0] expect_vec();
    if (!rst_n)                                           return 8'b0000_1111;
    if (mem_busy)                                         return 8'b1111_0001;
    if ((op_left > 0) || (ex_multicycle && !cooldown))    return 8'b1110_0010;
    if (branch_taken)                                     return 8'b0000_1100;
    if (load_use)                                         return 8'b1100_0100;
    return 8'b0000_0000;
  endfunction

  // Model advance on each rising edge, using the inputs of the ending cycle.
  always @(posedge clk) begin
    logic [7:0] e;
    e = expect_vec();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (cnt_clr) begin
        stall_big   = 0;
        stall_small = 0;
      end else if (e[7]) begin
        if (stall_big < 64'h0000_0000_FFFF_FFFF) stall_big++;
        if (stall_small < 15) stall_small++;
      end
      if (!mem_busy) begin
        if (op_left > 0) begin
          op_left--;
          if (op_left == 0) cooldown = 1'b1;
        end else if (ex_multicycle && !cooldown) begin
          op_left = MC_LAT - 1;
        end else begin
          cooldown = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) model_reset();
    e = expect_vec();
    checkOutput("ctrl_vec", dut_vec, e);
    checkOutput("small_ctrl_vec", s_vec, e);
    checkOutput("stall_cycles", stall_cycles, stall_big);
    checkOutput("small_stall_cycles", s_stall_cycles, stall_small);
  end

  initial begin
    rst_n         = 1'b0;
    mem_busy      = 1'b0;
    ex_multicycle = 1'b0;
    branch_taken  = 1'b0;
    load_use      = 1'b0;
    cnt_clr       = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_clear_de", clear_de, 1);
    checkOutput("rst_clear_wb", clear_wb, 1);
    checkOutput("rst_hold_fe", hold_fe, 0);
    checkOutput("rst_stall", stall_cycles, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("run_idle_vec", dut_vec, 8'h00);

    // Multicycle op of MC_LAT=4 with ex_multicycle held through MC_DONE
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 1, 0, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("mc_hold_ex_c%0d", c), hold_ex, (c < 4));
    end
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("mc_after_vec", dut_vec, 8'h00);
    checkOutput("mc_stall", stall_cycles, 4);

    // mem_busy in cycles 2-4 of the MC_WAIT freezes the countdown
    applyStimulus(0, 0, 0, 0, 1);
    for (int c = 0; c < 8; c++) begin
      logic mb;
      mb = (c >= 2) && (c <= 4);
      applyStimulus(mb, 1, 0, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("mb_clear_wb_c%0d", c), clear_wb, mb);
      checkOutput($sformatf("mb_hold_ex_c%0d", c), hold_ex, (c < 7));
    end
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("mb_stall", stall_cycles, 7);

    // branch_taken beats load_use in the same RUN cycle
    applyStimulus(0, 0, 1, 1, 0);
    @(negedge clk);
    checkOutput("br_lu_clear_de", clear_de, 1);
    checkOutput("br_lu_clear_ex", clear_ex, 1);
    checkOutput("br_lu_hold_fe", hold_fe, 0);
    checkOutput("br_lu_hold_de", hold_de, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("br_lu_stall", stall_cycles, 7);

    // Single load-use bubble
    applyStimulus(0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("lu_hold_fe", hold_fe, 1);
    checkOutput("lu_hold_de", hold_de, 1);
    checkOutput("lu_clear_ex", clear_ex, 1);
    checkOutput("lu_hold_ex", hold_ex, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lu_after_hold_fe", hold_fe, 0);
    checkOutput("lu_after_clear_ex", clear_ex, 0);
    checkOutput("lu_stall", stall_cycles, 8);

    // branch_taken ignored in MC_WAIT, honoured in MC_DONE
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 1, (c >= 2), 0, 0);
      @(negedge clk);
      if (c == 4) begin
        checkOutput("mcbr_done_clear_de", clear_de, 1);
        checkOutput("mcbr_done_clear_ex", clear_ex, 1);
        checkOutput("mcbr_done_hold_ex", hold_ex, 0);
      end else if (c >= 2) begin
        checkOutput($sformatf("mcbr_wait_clear_de_c%0d", c), clear_de, 0);
        checkOutput($sformatf("mcbr_wait_hold_ex_c%0d", c), hold_ex, 1);
      end
    end
    applyStimulus(0, 0, 0, 0, 0);

    // Reset in the middle of MC_WAIT
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_vec", dut_vec, 8'h0F);
    checkOutput("midrst_stall", stall_cycles, 0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    ex_multicycle = 1'b0;
    @(negedge clk);
    checkOutput("postrst_vec", dut_vec, 8'h00);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("postrst_hold_ex_c%0d", c), hold_ex, 0);
    end

    // 4-bit counter saturation, then clear during a hold cycle
    for (int c = 0; c < 20; c++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("sat_small_stall", s_stall_cycles, 15);
    checkOutput("sat_big_stall", stall_cycles, 20);
    checkOutput("sat_hold_fe", hold_fe, 1);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("clr_small_stall", s_stall_cycles, 0);
    checkOutput("clr_big_stall", stall_cycles, 0);

    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
